display_drop_ctrl: RTL

//  Registered, parametrised baggage-drop controller: classifies t_act vs t_lim (cold/hot), debounces the class,

---
 rtl/baggage_drop_pkg.sv | 37 +++
 rtl/temp_class_filter.sv | 64 ++++++
 rtl/display_drop_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/baggage_drop_pkg.sv
// Shared glyphs, FSM state type and message decode for the baggage-drop controller.
package baggage_drop_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_H     = 7'b1110110;
  localparam logic [6:0] SEG_O     = 7'b1011100;
  localparam logic [6:0] SEG_T     = 7'b1111000;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_L     = 7'b0111000;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_R     = 7'b1010000;
  localparam logic [6:0] SEG_P     = 7'b1110011;
  localparam logic [6:0] SEG_N     = 7'b1010100;
  localparam logic [6:0] SEG_E     = 7'b1111001;

  typedef enum logic [1:0] {
    ST_HOT,
    ST_COLD,
    ST_DROP,
    ST_LOCK
  } state_t;

  // Four digits packed leftmost-first.
  function automatic logic [27:0] msg_segs(input state_t s);
    logic [27:0] r;
    r = {4{SEG_BLANK}};
    unique case (s)
      ST_HOT:  r = {SEG_BLANK, SEG_H, SEG_O, SEG_T};
      ST_COLD: r = {SEG_C, SEG_O, SEG_L, SEG_D};
      ST_DROP: r = {SEG_D, SEG_R, SEG_O, SEG_P};
      ST_LOCK: r = {SEG_D, SEG_O, SEG_N, SEG_E};
      default: r = {4{SEG_BLANK}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/temp_class_filter.sv
// Cold/hot classifier with settle debounce.
// DISPLAY_DROP_HYST_EN adds a hysteresis band around t_lim.
module temp_class_filter
  import baggage_drop_pkg::*;
#(
  parameter int TEMP_W        = 16,
  parameter int SETTLE_CYCLES = 4
`ifdef DISPLAY_DROP_HYST_EN
  ,
  parameter int HYST          = 2
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TEMP_W-1:0] i_t_act,
  input  logic [TEMP_W-1:0] i_t_lim,
  output logic              o_filt_cold
);

  localparam int RW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(SETTLE_CYCLES - 1);

  logic          r_filt_cold;
  logic [RW-1:0] r_run;
  logic          w_raw_cold;

`ifdef DISPLAY_DROP_HYST_EN
  logic [TEMP_W:0] w_act_h;
  logic [TEMP_W:0] w_lim_h;

  assign w_act_h = {1'b0, i_t_act} + (TEMP_W+1)'(HYST);
  assign w_lim_h = {1'b0, i_t_lim} + (TEMP_W+1)'(HYST);

  // The band edge depends on which side we are currently on.
  always_comb begin
    w_raw_cold = r_filt_cold;
    if (r_filt_cold)
      w_raw_cold = !({1'b0, i_t_act} > w_lim_h);
    else
      w_raw_cold = (w_act_h < {1'b0, i_t_lim});
  end
`else
  assign w_raw_cold = (i_t_act < i_t_lim);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_filt_cold <= 1'b0;
      r_run       <= '0;
    end else if (w_raw_cold != r_filt_cold) begin
      if (r_run == RUN_LAST) begin
        r_filt_cold <= w_raw_cold;
        r_run       <= '0;
      end else begin
        r_run <= r_run + RW'(1);
      end
    end else begin
      r_run <= '0;
    end
  end

  assign o_filt_cold = r_filt_cold;

endmodule

// File: rtl/display_drop_ctrl.sv
// Baggage-drop controller: debounced class, timed drop FSM, 4-digit display.
// DISPLAY_DROP_HYST_EN enables hysteresis in the class filter.
module display_drop_ctrl
  import baggage_drop_pkg::*;
#(
  parameter int TEMP_W        = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int DROP_CYCLES   = 8,
  parameter int HYST          = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TEMP_W-1:0] t_act,
  input  logic [TEMP_W-1:0] t_lim,
  input  logic              drop_en,
  input  logic              drop_ack,
  output logic [6:0]        seven_seg1,
  output logic [6:0]        seven_seg2,
  output logic [6:0]        seven_seg3,
  output logic [6:0]        seven_seg4,
  output logic              drop_activated,
  output logic              drop_abort,
  output logic              busy
);

  localparam int TW = $clog2(DROP_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DROP_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_abort;
  logic          w_abort_nxt;
  logic          w_filt_cold;

  temp_class_filter #(
    .TEMP_W       (TEMP_W),
`ifdef DISPLAY_DROP_HYST_EN
    .HYST         (HYST),
`endif
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_filt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_t_act    (t_act),
    .i_t_lim    (t_lim),
    .o_filt_cold(w_filt_cold)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_abort_nxt = 1'b0;
    unique case (r_state)
      ST_HOT: begin
        if (w_filt_cold) begin
          w_state_nxt = drop_en ? ST_DROP : ST_COLD;
          w_timer_nxt = '0;
        end
      end
      ST_COLD: begin
        if (!w_filt_cold) begin
          w_state_nxt = ST_HOT;
        end else if (drop_en) begin
          w_state_nxt = ST_DROP;
          w_timer_nxt = '0;
        end
      end
      ST_DROP: begin
        // Abort paths outrank ack and timeout.
        if (!w_filt_cold) begin
          w_state_nxt = ST_HOT;
          w_abort_nxt = 1'b1;
        end else if (!drop_en) begin
          w_state_nxt = ST_COLD;
          w_abort_nxt = 1'b1;
        end else if (drop_ack || (r_timer == TIMER_LAST)) begin
          w_state_nxt = ST_LOCK;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_LOCK: begin
        if (!drop_en)
          w_state_nxt = w_filt_cold ? ST_COLD : ST_HOT;
      end
      default: w_state_nxt = ST_HOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_HOT;
      r_timer <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign {seven_seg1, seven_seg2, seven_seg3, seven_seg4} = msg_segs(r_state);
  assign drop_activated = (r_state == ST_DROP);
  assign busy           = (r_state == ST_DROP) || (r_state == ST_LOCK);
  assign drop_abort     = r_abort;

endmodule
